tag_control: RTL

- Command tag manager for the PSL command/response path.
- Allocates 8-bit PSL command tags from a free list and stores the CommandTagLine for each tag in use.
- When a PSL response returns a tag, it looks up the stored CommandTagLine and drives response_tag_id_out, which the response switching stage consumes as response_tag_id_in, then frees the tag.
- Lookup latency is exactly one cycle, so the output is aligned with the response stage's latched response.

---
 rtl/tag_control_pkg.sv | 30 +++
 rtl/parity.sv | 11 +
 rtl/tag_free_fifo.sv | 41 ++++
 rtl/tag_control.sv | 134 +++++++++++++
 4 files changed

// File: rtl/tag_control_pkg.sv
// Shared types for the PSL command tag manager: tag pool size, the per-tag
// CommandTagLine record, error flags and controller states.
package tag_control_pkg;

  localparam int TAG_COUNT = 32;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_TOUCH = 2'd2,
    CMD_INTR  = 2'd3
  } cmd_type_t;

  typedef struct packed {
    cmd_type_t   cmd_type;
    logic [7:0]  context_id;
    logic [15:0] ea_tag;
  } CommandTagLine;

  typedef struct packed {
    logic bad_free;
    logic out_of_range;
  } TagErrorType;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } TagControlState;

endpackage

// File: rtl/parity.sv
// Reduction parity over BITS inputs; ODD=1 yields odd parity (1 when the
// number of set bits is even).
module parity #(
  parameter int BITS = 8,
  parameter bit ODD  = 1'b1
) (
  input  logic [BITS-1:0] data,
  output logic            par
);
  assign par = ODD ? ~^data : ^data;
endmodule

// File: rtl/tag_free_fifo.sv
// Free-tag ID FIFO of DEPTH entries; pointers carry a wrap bit so that
// full and empty are distinguishable and count is a plain subtraction.
module tag_free_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 8,
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             push,
  input  logic [W-1:0]     push_id,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [AW:0]  used;

  assign used  = wr_ptr - rd_ptr;
  assign count = CNT_W'(used);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_id;
  end
endmodule

// File: rtl/tag_control.sv
// PSL command tag manager: grants tags from a free list, stores the
// CommandTagLine per tag and returns it on response. Macro TAG_CONTROL_STATS_EN
// adds max_outstanding and grant_stall_count.
module tag_control
  import tag_control_pkg::*;
#(
  parameter int NUM_TAGS  = TAG_COUNT,
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 enabled,
  input  logic                 tag_request,
  input  CommandTagLine        cmd_tag_line_in,
  output logic                 tag_grant,
  output logic [0:TAG_WIDTH-1] tag_out,
  output logic                 tag_out_parity,
  output logic [0:8]           tags_available,
  output logic                 tag_ready,
  input  logic                 response_valid,
  input  logic [0:TAG_WIDTH-1] response_tag,
  output CommandTagLine        response_tag_id_out,
  output logic [0:1]           tag_error,
  output TagControlState       state_dbg
`ifdef TAG_CONTROL_STATS_EN
  ,
  output logic [0:8]           max_outstanding,
  output logic [0:31]          grant_stall_count
`endif
);
  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int CMP_W = TAG_WIDTH + 1;

  TagControlState       state;
  logic [IDX_W-1:0]     init_cnt;
  logic [NUM_TAGS-1:0]  outstanding;
  CommandTagLine        tag_table [NUM_TAGS];
  TagErrorType          err_q;

  logic [TAG_WIDTH-1:0] fifo_head, push_id, rtag;
  logic [8:0]           fifo_count;
  logic                 fifo_empty, fifo_push, head_par;
  logic                 in_ready, do_alloc, rsp_fire, rsp_oor, rsp_live;
  logic [IDX_W-1:0]     rsp_idx, alloc_idx;

  // tag_request has no backpressure: a request seen with an empty free list is
  // simply dropped, and tag_grant one cycle later is the only acknowledgement.
  assign rtag      = response_tag;
  assign in_ready  = (state == READY);
  assign do_alloc  = in_ready && enabled && tag_request && !fifo_empty;
  assign rsp_fire  = in_ready && enabled && response_valid;
  assign rsp_oor   = {1'b0, rtag} >= CMP_W'(NUM_TAGS);
  assign rsp_idx   = rtag[IDX_W-1:0];
  assign alloc_idx = fifo_head[IDX_W-1:0];
  assign rsp_live  = rsp_fire && !rsp_oor && outstanding[rsp_idx];
  assign fifo_push = (state == INIT) || rsp_live;
  assign push_id   = (state == INIT) ? TAG_WIDTH'(init_cnt) : rtag;

  tag_free_fifo #(.DEPTH(NUM_TAGS), .W(TAG_WIDTH), .CNT_W(9)) u_free (
    .clock   (clock),
    .rstn    (rstn),
    .push    (fifo_push),
    .push_id (push_id),
    .pop     (do_alloc),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  parity #(.BITS(TAG_WIDTH), .ODD(1'b1)) u_parity (
    .data (fifo_head),
    .par  (head_par)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state    <= INIT;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + IDX_W'(1);
      if (init_cnt == IDX_W'(NUM_TAGS - 1)) state <= READY;
    end
  end

  // A tag is freed only while outstanding, so the set and clear below never
  // target the same bit in one cycle.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      tag_grant           <= 1'b0;
      tag_out             <= '0;
      tag_out_parity      <= 1'b0;
      response_tag_id_out <= '0;
      err_q               <= '0;
      outstanding         <= '0;
    end else begin
      tag_grant <= do_alloc;
      if (do_alloc) begin
        tag_out                <= fifo_head;
        tag_out_parity         <= head_par;
        outstanding[alloc_idx] <= 1'b1;
      end
      if (rsp_live) outstanding[rsp_idx] <= 1'b0;
      response_tag_id_out <= rsp_live ? tag_table[rsp_idx] : '0;
      err_q.bad_free      <= rsp_fire && !rsp_oor && !outstanding[rsp_idx];
      err_q.out_of_range  <= rsp_fire && rsp_oor;
    end
  end

  always_ff @(posedge clock) begin
    if (do_alloc) tag_table[alloc_idx] <= cmd_tag_line_in;
  end

  assign tags_available = fifo_count;
  assign tag_ready      = in_ready && !fifo_empty;
  assign tag_error      = err_q;
  assign state_dbg      = state;

`ifdef TAG_CONTROL_STATS_EN
  logic [8:0] busy_now;
  assign busy_now = 9'(NUM_TAGS) - fifo_count;

  // Sampled only in READY; during INIT the filling free list is not usage.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      max_outstanding   <= '0;
      grant_stall_count <= '0;
    end else if (in_ready) begin
      if (busy_now > max_outstanding) max_outstanding <= busy_now;
      if (enabled && tag_request && fifo_empty && (grant_stall_count != '1))
        grant_stall_count <= grant_stall_count + 32'd1;
    end
  end
`endif
endmodule
